// File: rtl/debouncer_2ch_if.sv
// Raw and debounced signal bundle for the two-channel debouncer.
// master drives the raw lines; slave (the debouncer) returns the filtered levels.
interface debouncer_2ch_if;
  logic I0;
  logic I1;
  logic O0;
  logic O1;

  modport master (
    output I0,
    output I1,
    input  O0,
    input  O1
  );

  modport slave (
    input  I0,
    input  I1,
    output O0,
    output O1
  );
endinterface

// File: rtl/debouncer_2ch.sv
// Two independent debounce channels: 2-flop synchronizer, then a saturating stability
// counter that lets the output follow only after STABLE_CYCLES+1 matching samples.
module debouncer_2ch #(
  parameter int unsigned STABLE_CYCLES = 19,
  parameter logic        RESET_LEVEL   = 1'b1
) (
  input logic           clk,
  input logic           reset,
  debouncer_2ch_if.slave bus
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);

  logic [1:0] raw;
  logic [1:0] deb;

  assign raw    = {bus.I1, bus.I0};
  assign bus.O0 = deb[0];
  assign bus.O1 = deb[1];

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic            sync1_q;
    logic            sync2_q;
    logic            iv_q;
    logic            iv_d;
    logic            out_q;
    logic            out_d;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
      iv_d  = iv_q;
      cnt_d = cnt_q;
      out_d = out_q;
      if (sync2_q != iv_q) begin
        iv_d  = sync2_q;
        cnt_d = '0;
      end else if (cnt_q < CntMax) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        // Saturated: the sampled level has been stable for a full window.
        out_d = iv_q;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        sync1_q <= RESET_LEVEL;
        sync2_q <= RESET_LEVEL;
        iv_q    <= RESET_LEVEL;
        out_q   <= RESET_LEVEL;
        cnt_q   <= '0;
      end else begin
        sync1_q <= raw[c];
        sync2_q <= sync1_q;
        iv_q    <= iv_d;
        out_q   <= out_d;
        cnt_q   <= cnt_d;
      end
    end

    assign deb[c] = out_q;
  end

endmodule

// File: tb/tb_debouncer_2ch.sv
// Self-checking bench for debouncer_2ch: directed vector table, hand-written latency and
// bounce sequences, then randomized traffic checked against a run-length reference model.
module tb_debouncer_2ch;

  localparam int unsigned S = 19;
  localparam logic        R = 1'b1;
  localparam int          Win = int'(S) + 2;  // equal synchronized samples needed to switch
  localparam int          Lat = int'(S) + 4;  // edges from first sample to new output

  logic clk = 1'b0;
  logic reset;
  logic i0;
  logic i1;

  always #5 clk = ~clk;

  debouncer_2ch_if bus ();
  assign bus.I0 = i0;
  assign bus.I1 = i1;

  debouncer_2ch #(
    .STABLE_CYCLES(S),
    .RESET_LEVEL  (R)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int passed = 0;
  int total  = 0;
  bit model_on = 1'b0;

  // Reference model: raw input delayed two edges, then track the length of the current run
  // of equal delayed samples; the output adopts that level once the run reaches Win.
  logic m_d1 [2];
  logic m_d2 [2];
  logic m_runv [2];
  int   m_len [2];
  logic m_out [2];

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_edge();
    logic r [2];
    logic s;
    r[0] = i0;
    r[1] = i1;
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        m_d1[c] = R;
        m_d2[c] = R;
        m_runv[c] = R;
        m_len[c] = 1;
        m_out[c] = R;
      end else begin
        s = m_d2[c];
        m_d2[c] = m_d1[c];
        m_d1[c] = r[c];
        if (s == m_runv[c]) begin
          if (m_len[c] < Win) m_len[c]++;
        end else begin
          m_runv[c] = s;
          m_len[c] = 1;
        end
        if (m_len[c] >= Win) m_out[c] = m_runv[c];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (model_on) begin
      check("model_o0", bus.O0, m_out[0]);
      check("model_o1", bus.O1, m_out[1]);
    end
  endtask

  typedef struct {
    string name;
    bit    rst;
    bit    v0;
    bit    v1;
    int    cyc;
    bit    e0;
    bit    e1;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string n, bit r, bit a, bit b, int c, bit e0, bit e1);
    vec_t v;
    v.name = n; v.rst = r; v.v0 = a; v.v1 = b; v.cyc = c; v.e0 = e0; v.e1 = e1;
    vecs.push_back(v);
  endfunction

  int   rem [2];
  logic lvl [2];

  initial begin
    reset = 1'b1;
    i0 = 1'b1;
    i1 = 1'b1;
    tick();
    tick();
    model_on = 1'b1;

    add("reset_idle",      1, 1, 1,  2, 1, 1);
    add("idle_hold",       0, 1, 1, 30, 1, 1);
    add("i0_fall_22",      0, 0, 1, 22, 1, 1);
    add("i0_fall_23",      0, 0, 1,  1, 0, 1);
    add("i1_pulse10",      0, 0, 0, 10, 0, 1);
    add("i1_pulse10_after",0, 0, 1, 30, 0, 1);
    add("i1_pulse25",      0, 0, 0, 25, 0, 0);
    add("i1_rise_22",      0, 0, 1, 22, 0, 0);
    add("i1_rise_23",      0, 0, 1,  1, 0, 1);
    add("opposite_22",     0, 1, 0, 22, 0, 1);
    add("opposite_23",     0, 1, 0,  1, 1, 0);
    add("i0_low15",        0, 0, 0, 15, 1, 0);
    add("reset_mid",       1, 0, 0,  1, 1, 1);
    add("post_reset_22",   0, 0, 0, 22, 1, 1);
    add("post_reset_23",   0, 0, 0,  1, 0, 0);
    add("restore_i0",      0, 1, 0, 30, 1, 0);

    foreach (vecs[k]) begin
      reset = vecs[k].rst;
      i0 = vecs[k].v0;
      i1 = vecs[k].v1;
      repeat (vecs[k].cyc) tick();
      check({vecs[k].name, "_o0"}, bus.O0, vecs[k].e0);
      check({vecs[k].name, "_o1"}, bus.O1, vecs[k].e1);
    end

    // Bounce every 5 cycles, ending high, then settle low.
    for (int n = 0; n < 200; n++) begin
      i0 = ((n / 5) % 2) != 0;
      tick();
      check("bounce_o0", bus.O0, 1'b1);
      check("bounce_o1", bus.O1, 1'b0);
    end
    i0 = 1'b0;
    for (int n = 1; n <= Lat; n++) begin
      tick();
      check("settle_o0", bus.O0, (n < Lat) ? 1'b1 : 1'b0);
    end

    // Randomized runs of 1..45 cycles per channel with occasional resets.
    rem[0] = 0;
    rem[1] = 0;
    lvl[0] = 1'b0;
    lvl[1] = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (rem[c] == 0) begin
          lvl[c] = 1'($urandom_range(0, 1));
          rem[c] = int'($urandom_range(1, 45));
        end
        rem[c]--;
      end
      i0 = lvl[0];
      i1 = lvl[1];
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
